// File: rtl/debounced_input_port.sv
// debounced_input_port
// N-channel input port with per-bit synchroniser, debounce filter, edge
// capture and maskable level interrupt, on a PIO-compatible Avalon-MM slave.
// Register map (word offsets): 0 data, 1 direction (reads 0), 2 irq_mask,
// 3 edge_capture (write-1-to-clear, an edge in the same cycle wins).

module debounced_input_port #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 1,
   parameter int IDLE_LEVEL      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic           IDLE_BIT = (IDLE_LEVEL != 0);

   // synchroniser chain, stage SYNC_STAGES-1 feeds the filter
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_in_s;

   // debounce state
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] stable_dly_q;

   // edge detection and register file
   logic [WIDTH-1:0] edge_set_s;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] clr_s;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             wr_en_s, rd_en_s;

   // upper write-data bits have no destination in a narrow port
   logic             unused_wdata;
   assign unused_wdata = ^writedata;

   assign sync_in_s = sync_q[SYNC_STAGES-1];
   assign wr_en_s   = chipselect & write;
   assign rd_en_s   = chipselect & read;
   assign readdata  = readdata_q;
   assign irq       = irq_q;

   // shift raw pins through the synchroniser flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= {WIDTH{IDLE_BIT}};
         end
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // per-bit debounce: count consecutive differing cycles, accept on the last
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_in_s[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync_in_s[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // debounce counters and accepted levels
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         stable_q     <= {WIDTH{IDLE_BIT}};
         stable_dly_q <= {WIDTH{IDLE_BIT}};
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
      end
   end

   // select which one-cycle edge pulse feeds the capture register
   always_comb begin
      edge_set_s = '0;
      case (EDGE_TYPE)
         32'd0:   edge_set_s = stable_q & ~stable_dly_q;
         32'd1:   edge_set_s = ~stable_q & stable_dly_q;
         default: edge_set_s = stable_q ^ stable_dly_q;
      endcase
   end

   // register-file next state and registered read mux
   always_comb begin
      mask_d     = mask_q;
      clr_s      = '0;
      readdata_d = readdata_q;
      if (wr_en_s && (address == 2'd2)) begin
         mask_d = writedata[WIDTH-1:0];
      end else begin
         mask_d = mask_q;
      end
      if (wr_en_s && (address == 2'd3)) begin
         clr_s = writedata[WIDTH-1:0];
      end else begin
         clr_s = '0;
      end
      // set is applied after clear so a coincident edge keeps the bit
      cap_d = (cap_q & ~clr_s) | edge_set_s;
      irq_d = |(cap_q & mask_q);
      if (rd_en_s) begin
         case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd1:    readdata_d = 32'd0;
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(cap_q);
            default: readdata_d = 32'd0;
         endcase
      end else begin
         readdata_d = readdata_q;
      end
   end

   // mask, capture, read data and interrupt registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q     <= '0;
         cap_q      <= '0;
         readdata_q <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: tb/tb_debounced_input_port.sv
// Bench for debounced_input_port: two instances (falling-edge and any-edge
// capture) share stimulus; a cycle-level behavioural model predicts readdata
// and irq of both every cycle, and directed phases pin literal values.

module tb_debounced_input_port;

   localparam int W  = 4;
   localparam int DC = 8;
   localparam int S  = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  pin = 4'hF;
   logic [1:0]  addr = 2'd0;
   logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [31:0] wd = 32'd0;
   logic [31:0] rdata0, rdata1;
   logic        irq0, irq1;

   int checks = 0;
   int passes = 0;

   // model state
   logic [3:0]  m_stable;
   logic [3:0]  m_cap [2];
   logic [3:0]  m_pend [2];
   logic [3:0]  m_mask [2];
   logic        m_irq [2];
   logic [31:0] m_rd [2];
   logic [3:0]  pin_q [$];
   logic [3:0]  sync_q [$];

   debounced_input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(S),
                          .EDGE_TYPE(1), .IDLE_LEVEL(1)) dut_fall (
      .clk(clk), .reset_n(reset_n), .in_port(pin), .address(addr),
      .chipselect(cs), .read(rd), .write(wr), .writedata(wd),
      .readdata(rdata0), .irq(irq0));

   debounced_input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .SYNC_STAGES(S),
                          .EDGE_TYPE(2), .IDLE_LEVEL(1)) dut_any (
      .clk(clk), .reset_n(reset_n), .in_port(pin), .address(addr),
      .chipselect(cs), .read(rd), .write(wr), .writedata(wd),
      .readdata(rdata1), .irq(irq1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_stable = 4'hF;
      for (int d = 0; d < 2; d++) begin
         m_cap[d] = 4'h0; m_pend[d] = 4'h0; m_mask[d] = 4'h0;
         m_irq[d] = 1'b0; m_rd[d] = 32'd0;
      end
      pin_q.delete();
      sync_q.delete();
   endtask

   function automatic logic [3:0] edges(input int d, input logic [3:0] o, input logic [3:0] n);
      if (d == 0) return o & ~n;
      else        return o ^ n;
   endfunction

   // one clock: advance the model on the inputs seen at the edge, then compare
   task automatic step();
      logic [3:0] sv, os, clr;
      logic       all_diff;
      @(posedge clk);
      sv = (pin_q.size() >= S) ? pin_q[pin_q.size()-S] : 4'hF;
      pin_q.push_back(pin);
      if (pin_q.size() > S) void'(pin_q.pop_front());
      sync_q.push_back(sv);
      if (sync_q.size() > DC) void'(sync_q.pop_front());
      os = m_stable;
      // a level is accepted once the last DC synchronised samples all differ
      for (int b = 0; b < W; b++) begin
         if (sync_q.size() == DC) begin
            all_diff = 1'b1;
            for (int e = 0; e < DC; e++)
               if (sync_q[e][b] == os[b]) all_diff = 1'b0;
            if (all_diff) m_stable[b] = ~os[b];
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (cs && rd) begin
            case (addr)
               2'd0: m_rd[d] = {28'd0, os};
               2'd2: m_rd[d] = {28'd0, m_mask[d]};
               2'd3: m_rd[d] = {28'd0, m_cap[d]};
               default: m_rd[d] = 32'd0;
            endcase
         end
         m_irq[d] = |(m_cap[d] & m_mask[d]);
         clr = (cs && wr && addr == 2'd3) ? wd[3:0] : 4'h0;
         m_cap[d] = (m_cap[d] & ~clr) | m_pend[d];
         if (cs && wr && addr == 2'd2) m_mask[d] = wd[3:0];
         m_pend[d] = edges(d, os, m_stable);
      end
      #1;
      chk("model_readdata_fall", rdata0, m_rd[0]);
      chk("model_readdata_any",  rdata1, m_rd[1]);
      chk("model_irq_fall", {31'd0, irq0}, {31'd0, m_irq[0]});
      chk("model_irq_any",  {31'd0, irq1}, {31'd0, m_irq[1]});
   endtask

   task automatic bus_idle();
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; wd = 32'd0;
   endtask

   task automatic rd_op(input logic [1:0] a);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      step();
      bus_idle();
   endtask

   task automatic wr_op(input logic [1:0] a, input logic [31:0] v);
      cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = a; wd = v;
      step();
      bus_idle();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int first;
      bit hit;
      int r;
      model_reset();
      bus_idle();
      pin = 4'hF;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // reset state
      steps(3);
      chk("reset_irq", {31'd0, irq0}, 32'd0);
      rd_op(2'd0);
      chk("reset_data", rdata0, 32'hF);
      rd_op(2'd3);
      chk("reset_capture", rdata1, 32'h0);

      // accept a held low on bit 1; first visible on read at edge S+8+1
      pin = 4'hD;
      cs = 1'b1; rd = 1'b1; addr = 2'd0;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (first == 0 && rdata0 == 32'hD) first = k;
      end
      bus_idle();
      chk("accept_latency", first, 11);
      rd_op(2'd3);
      chk("capture_fall_b1", rdata0, 32'h2);
      chk("capture_any_b1", rdata1, 32'h2);
      chk("irq_masked", {31'd0, irq0}, 32'd0);

      // mask enable raises irq one cycle later; W1C clears it
      wr_op(2'd2, 32'h2);
      chk("irq_same_cycle_as_mask", {31'd0, irq0}, 32'd0);
      step();
      chk("irq_after_mask", {31'd0, irq0}, 32'd1);
      chk("irq_after_mask_any", {31'd0, irq1}, 32'd1);
      wr_op(2'd3, 32'h2);
      step();
      chk("irq_after_clear", {31'd0, irq0}, 32'd0);

      // bounce on bit 0 is rejected, then a full hold is accepted
      pin = 4'hC; steps(5);
      pin = 4'hD; steps(1);
      pin = 4'hC; steps(5);
      rd_op(2'd0);
      chk("bounce_data", rdata0, 32'hD);
      rd_op(2'd3);
      chk("bounce_capture", rdata0, 32'h0);
      steps(8);
      rd_op(2'd0);
      chk("held_data", rdata0, 32'hC);
      rd_op(2'd3);
      chk("held_capture", rdata0, 32'h1);

      // any-edge capture on bit 3, clear colliding with the rising edge
      wr_op(2'd3, 32'hF);
      pin = 4'h4; steps(12);
      rd_op(2'd3);
      chk("bit3_fall_fall", rdata0, 32'h8);
      chk("bit3_fall_any", rdata1, 32'h8);
      pin = 4'hC;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         if (m_pend[1][3]) begin
            cs = 1'b1; wr = 1'b1; addr = 2'd3; wd = 32'h8; hit = 1'b1;
         end
         step();
         bus_idle();
      end
      chk("collision_seen", {31'd0, hit}, 32'd1);
      rd_op(2'd3);
      chk("set_wins_any", rdata1, 32'h8);
      chk("cleared_fall", rdata0, 32'h0);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 5) == 0) pin[$urandom_range(0, 3)] = ~pin[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) pin ^= 4'(1 << $urandom_range(0, 3));
         r = $urandom_range(0, 9);
         if (r < 4) begin
            cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 2'($urandom_range(0, 3));
         end else if (r < 6) begin
            cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = 2'($urandom_range(0, 3)); wd = $urandom;
         end else if (r == 6) begin
            cs = 1'b0; rd = 1'b1; wr = 1'b1; addr = 2'($urandom_range(0, 3)); wd = $urandom;
         end else begin
            bus_idle();
         end
         step();
      end
      bus_idle();

      // reset in the middle of a debounce count
      pin = 4'hF; steps(12);
      wr_op(2'd3, 32'hF);
      wr_op(2'd2, 32'hF);
      pin = 4'hB; steps(12);
      chk("pre_reset_irq", {31'd0, irq0}, 32'd1);
      rd_op(2'd0);
      chk("pre_reset_data", rdata0, 32'hB);
      pin = 4'hA; steps(7);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_rdata", rdata0, 32'd0);
      chk("async_reset_irq", {31'd0, irq1}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      cs = 1'b1; rd = 1'b1; addr = 2'd0;
      steps(10);
      chk("post_reset_not_yet", rdata0, 32'hF);
      step();
      chk("post_reset_accept", rdata0, 32'hA);
      bus_idle();
      rd_op(2'd2);
      chk("post_reset_mask", rdata0, 32'h0);
      rd_op(2'd3);
      chk("post_reset_cap_fall", rdata0, 32'h5);
      chk("post_reset_cap_any", rdata1, 32'h5);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/debounced_input_port.md
Name: debounced_input_port

Overview:
- Parametrised successor to the plain pushbutton/slider-switch input ports on the Nios II system bus.
- Per channel, N inputs get a synchroniser, a debounce filter, selectable edge capture and a maskable interrupt.
- Registers use the standard PIO map (data/direction/mask/edge at word offsets 0-3) on an Avalon-MM slave, so existing KEY/SW driver code still works.
- Sits between board pins (KEY[3:1], SW[17:0], GPIO) and the system interconnect.

Parameters:
- WIDTH, 4, number of input channels (1-32).
- DEBOUNCE_CYCLES, 500000, clock cycles an input must stay at a new level before it is accepted (10 ms at 50 MHz); must be >= 2.
- SYNC_STAGES, 2, synchroniser flop depth (>= 2).
- EDGE_TYPE, 1, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- IDLE_LEVEL, 1, reset value of the synchroniser and debounced state (1 suits active-low KEYs).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_port  in  WIDTH  raw asynchronous pin inputs.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- irq  out  1  interrupt request, level, active-high.

Behaviour:
- Reset is asynchronous on the falling edge of reset_n and is released synchronously by the next clk edge. On reset:
  - synchroniser flops and debounced state are all set to IDLE_LEVEL;
  - debounce counters are 0;
  - irq_mask is 0 and edge_capture is 0;
  - readdata is 0 and irq is 0.
- Synchroniser: SYNC_STAGES flops per bit; sync_in is the last stage.
- Debounce, per bit i, independent counter of width clog2(DEBOUNCE_CYCLES):
  - If sync_in[i] == stable[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, stable[i] takes sync_in[i] and the counter clears. The new level is therefore accepted after exactly DEBOUNCE_CYCLES consecutive differing cycles.
  - Any glitch back to the stable level restarts the count. The counter never wraps.
- Edge detect: the rise/fall pulse is one cycle, in the cycle after stable[i] changes. EDGE_TYPE selects which pulse sets edge_capture[i].
- Register map (read and write take effect only when chipselect is high):
  - offset 0 (data): read returns {0, stable}; writes are ignored.
  - offset 1 (direction): reads 0; writes are ignored.
  - offset 2 (irq_mask): read/write, WIDTH bits; upper bits read 0.
  - offset 3 (edge_capture): read returns captured bits; a write clears every bit set in writedata (write-1-to-clear).
- Simultaneous edge-set and clear on the same bit in the same cycle: set wins, so the bit stays 1.
- Read latency 1: readdata updates on the clk edge after a read with chipselect and holds its value until the next read. No wait states.
- irq = |(edge_capture & irq_mask), registered, so it has one cycle of latency from the capture or mask change.
- Reset mid-debounce discards the partial count. No edge is generated by reset itself.

Test Plan:
- WIDTH=4, DEBOUNCE_CYCLES=8, EDGE_TYPE=1, in_port=4'hF held through reset, then reset released -> data reads 0xF, edge_capture 0, irq 0.
- in_port[1] driven 0 and held -> data reads 0xD no earlier than SYNC_STAGES+8 cycles after the drive; edge_capture reads 0x2; irq stays 0 while mask is 0.
- irq_mask written 0x2 with edge_capture 0x2 pending -> irq=1 one cycle later. Writing 0x2 to offset 3 -> edge_capture 0, irq=0 the next cycle.
- Bounce in_port[0]: low 5 cycles, high 1 cycle, low 5 cycles -> no change to data or capture. Then hold low 8 cycles -> data bit0=0 and capture bit0=1.
- EDGE_TYPE=2: toggle bit3 low then high, each held 8+ cycles -> capture bit3 set after each edge. A clear write landing in the same cycle as the second edge leaves bit3=1.
- Assert reset_n low with a counter at 5 -> irq, readdata, mask and capture go 0 immediately, without waiting for a clk edge. After release, a held differing input needs the full 8 cycles to be accepted.
